// File: rtl/regwb_pkg.sv
// regwb_pkg: shared types and constants for the register-file writeback
// controller.
//   AW / DW     : register address / data widths
//   reg_addr_t  : register index
//   reg_data_t  : register value
//   wb_entry_t  : one pending writeback {addr, data}
//   REG_ZERO    : the hard-wired zero register, never written
//   grant_t     : which source won the last arbitration
package regwb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_t;

endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: synchronous FIFO of wb_entry_t holding buffered load results.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-low reset
//   push, din     : enqueue din (ignored when full)
//   pop, dout     : dequeue; dout is the current head (valid when !empty)
//   count         : registered occupancy, 0..DEPTH
//   full, empty   : decoded from count only
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback controller for the 32x32 register file write
// port. ALU results arrive unbuffered, load results are buffered in a
// regwb_fifo; one source is granted per cycle and its entry is written one
// cycle later through registered wr_en / wr_addr / wr_data. Register 0 is
// never written.
// Ports:
//   clk, reset                  : rising-edge clock, async active-low reset
//   alu_valid/ready/addr/data   : ALU result handshake
//   mem_valid/ready/addr/data   : load result handshake into the FIFO
//   wr_en, wr_addr, wr_data     : register file write port (written/AD/DI)
//   fifo_count                  : load FIFO occupancy
// Optional macro REGWB_BYPASS_EN adds ra1/ra2, rf_q1/rf_q2 inputs and
// fwd_q1/fwd_q2 outputs forwarding the in-flight write to readers.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// ALU's ready is combinational (high only in the cycle it wins arbitration);
// mem_ready depends only on the registered FIFO count, so a pop in the same
// cycle never opens room for a push.
module regfile_wb_ctrl
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = regwb_pkg::AW,
  parameter int DW    = regwb_pkg::DW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [AW-1:0]                alu_addr,
  input  logic [DW-1:0]                alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_addr,
  input  logic [DW-1:0]                mem_data,
  output logic                         wr_en,
  output logic [AW-1:0]                wr_addr,
  output logic [DW-1:0]                wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [AW-1:0]                ra1,
  input  logic [AW-1:0]                ra2,
  input  logic [DW-1:0]                rf_q1,
  input  logic [DW-1:0]                rf_q2,
  output logic [DW-1:0]                fwd_q1,
  output logic [DW-1:0]                fwd_q2
`endif
);

  wb_entry_t alu_entry;
  wb_entry_t push_entry;
  wb_entry_t head;
  wb_entry_t grant_entry;
  logic      full;
  logic      empty;
  logic      grant_alu;
  logic      grant_ld;
  grant_t    last_grant;

  assign alu_entry  = '{addr: alu_addr, data: alu_data};
  assign push_entry = '{addr: mem_addr, data: mem_data};
  assign mem_ready  = !full;
  assign alu_ready  = grant_alu;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_valid && mem_ready),
    .din   (push_entry),
    .pop   (grant_ld),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // A full FIFO always takes priority so loads cannot back up behind a
  // continuous ALU stream; otherwise the two sources alternate.
  always_comb begin
    grant_ld    = !empty && (!alu_valid || full || (last_grant == GRANT_ALU));
    grant_alu   = alu_valid && !grant_ld;
    grant_entry = grant_ld ? head : alu_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_ALU;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else if (grant_alu || grant_ld) begin
      last_grant <= grant_ld ? GRANT_LD : GRANT_ALU;
      // A grant to register 0 is consumed but never reaches the file.
      wr_en      <= (grant_entry.addr != REG_ZERO);
      wr_addr    <= grant_entry.addr;
      wr_data    <= grant_entry.data;
    end else begin
      wr_en      <= 1'b0;
    end
  end

`ifdef REGWB_BYPASS_EN
  // Readers in the write cycle see the value being written this edge.
  assign fwd_q1 = (wr_en && (wr_addr == ra1) && (ra1 != REG_ZERO)) ? wr_data : rf_q1;
  assign fwd_q2 = (wr_en && (wr_addr == ra2) && (ra2 != REG_ZERO)) ? wr_data : rf_q2;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed bench for regfile_wb_ctrl (DEPTH = 4).
// Inputs change 1 time unit after a rising edge; outputs are checked there
// (registered) or 1 unit after an input change (combinational).
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;
`ifdef REGWB_BYPASS_EN
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rf_q1;
  logic [31:0] rf_q2;
  logic [31:0] fwd_q1;
  logic [31:0] fwd_q2;
`endif

  int checks;
  int failures;

  regfile_wb_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fifo_count (fifo_count)
`ifdef REGWB_BYPASS_EN
    ,
    .ra1        (ra1),
    .ra2        (ra2),
    .rf_q1      (rf_q1),
    .rf_q2      (rf_q2),
    .fwd_q1     (fwd_q1),
    .fwd_q2     (fwd_q2)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_en"}, {31'd0, wr_en}, 32'd1);
    chk({tag, "_addr"}, {27'd0, wr_addr}, {27'd0, a});
    chk({tag, "_data"}, wr_data, d);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
  endtask

  // Hand-derived contention schedule, cycle c = bit c.
  // ALU wins on even cycles; FIFO is full (no push) in cycles 7 and 9.
  bit [9:0] ardy_v = 10'b0101010101;
  bit [9:0] mrdy_v = 10'b0101111111;
  int       cnt_v [10] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3};

  initial begin
    int ai;
    int li;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
`ifdef REGWB_BYPASS_EN
    ra1 = '0; ra2 = '0; rf_q1 = '0; rf_q2 = '0;
`endif

    // Reset state
    step();
    step();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    reset = 1'b1;
    step();

    // ALU-only stream
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA;
    #1 chk("alu_rdy0", {31'd0, alu_ready}, 32'd1);
    step();
    chk_wr("alu_wr0", 5'd5, 32'hA);
    alu_addr = 5'd6; alu_data = 32'hB;
    #1 chk("alu_rdy1", {31'd0, alu_ready}, 32'd1);
    step();
    chk_wr("alu_wr1", 5'd6, 32'hB);
    alu_addr = 5'd7; alu_data = 32'hC;
    #1 chk("alu_rdy2", {31'd0, alu_ready}, 32'd1);
    step();
    chk_wr("alu_wr2", 5'd7, 32'hC);
    alu_valid = 1'b0;
    step();
    chk("alu_idle_en", {31'd0, wr_en}, 32'd0);
    chk("alu_idle_addr_hold", {27'd0, wr_addr}, 32'd7);
    chk("alu_idle_data_hold", wr_data, 32'hC);

    // Load stream with ALU idle: each load drains the cycle after it lands
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(10 + i); mem_data = 32'h100 + 32'(i);
      #1 chk("ld_mem_ready", {31'd0, mem_ready}, 32'd1);
      step();
      chk("ld_count", {29'd0, fifo_count}, 32'd1);
      if (i > 0) chk_wr("ld_wr", 5'(10 + i - 1), 32'h100 + 32'(i - 1));
    end
    mem_valid = 1'b0;
    step();
    chk_wr("ld_wr_last", 5'd14, 32'h104);
    chk("ld_count_empty", {29'd0, fifo_count}, 32'd0);
    step();
    chk("ld_idle_en", {31'd0, wr_en}, 32'd0);

    // Contention: round-robin, FIFO fills to 4 and then LD takes every
    // cycle where the FIFO is full
    ai = 0;
    li = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_addr = 5'(20 + ai); alu_data = 32'h200 + 32'(ai);
      mem_valid = 1'b1; mem_addr = 5'(1 + li);  mem_data = 32'h300 + 32'(li);
      #1;
      chk("ct_alu_ready", {31'd0, alu_ready}, {31'd0, ardy_v[c]});
      chk("ct_mem_ready", {31'd0, mem_ready}, {31'd0, mrdy_v[c]});
      step();
      chk("ct_count", {29'd0, fifo_count}, 32'(cnt_v[c]));
      if (c % 2 == 0) chk_wr("ct_wr_alu", 5'(20 + c / 2), 32'h200 + 32'(c / 2));
      else            chk_wr("ct_wr_ld",  5'(1 + (c - 1) / 2), 32'h300 + 32'((c - 1) / 2));
      if (ardy_v[c]) ai++;
      if (mrdy_v[c]) li++;
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk_wr("ct_drain", 5'(6 + k), 32'h305 + 32'(k));
      chk("ct_drain_count", {29'd0, fifo_count}, 32'(2 - k));
    end
    step();
    chk("ct_idle_en", {31'd0, wr_en}, 32'd0);

    // Register 0 suppression
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
    #1 chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    chk("r0_alu_wr_en", {31'd0, wr_en}, 32'd0);
    chk("r0_alu_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("r0_alu_wr_data", wr_data, 32'hDEAD);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBEEF;
    step();
    mem_valid = 1'b0;
    chk("r0_ld_count", {29'd0, fifo_count}, 32'd1);
    chk("r0_ld_en_a", {31'd0, wr_en}, 32'd0);
    step();
    chk("r0_ld_en_b", {31'd0, wr_en}, 32'd0);
    chk("r0_ld_popped", {29'd0, fifo_count}, 32'd0);
    // The suppressed load still counts as the last grant, so ALU wins next
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
    step();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    #1 chk("r0_rr_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk_wr("r0_rr_wr_alu", 5'd4, 32'h44);
    chk("r0_rr_count", {29'd0, fifo_count}, 32'd1);
    step();
    chk_wr("r0_rr_wr_ld", 5'd3, 32'h33);
    chk("r0_rr_count_empty", {29'd0, fifo_count}, 32'd0);

`ifdef REGWB_BYPASS_EN
    // Bypass forwarding
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    ra1 = 5'd9; rf_q1 = 32'h0;
    ra2 = 5'd0; rf_q2 = 32'h5555;
    #1;
    chk("byp_fwd_q1", fwd_q1, 32'h1234);
    chk("byp_fwd_q2_r0", fwd_q2, 32'h5555);
    step();
    chk("byp_fwd_q1_idle", fwd_q1, 32'h0);
`endif

    // Reset mid-burst with 3 loads buffered
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h77;
      mem_valid = 1'b1; mem_addr = 5'd15; mem_data = 32'h500 + 32'(i);
      step();
    end
    chk("mr_count_before", {29'd0, fifo_count}, 32'd3);
    chk_wr("mr_wr_before", 5'd15, 32'h502);
    reset = 1'b0;
    #1;
    chk("mr_wr_en_async", {31'd0, wr_en}, 32'd0);
    chk("mr_count_async", {29'd0, fifo_count}, 32'd0);
    chk("mr_mem_ready", {31'd0, mem_ready}, 32'd1);
    idle_inputs();
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_no_write", {31'd0, wr_en}, 32'd0);
      chk("mr_count_post", {29'd0, fifo_count}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
